// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the data memory load/store front end.
package data_mem_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10
    } size_e;

    typedef enum logic {
        IDLE,
        SECOND
    } state_e;

    function automatic logic [3:0] lane_mask(size_e size);
        case (size)
            SZ_B:    return 4'b0001;
            SZ_H:    return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane alignment: store byte-enable/data placement for both halves
// of a possibly split access, and load extraction/extension from a 64-bit window.
module lsu_align
    import data_mem_pkg::*;
(
    input  logic [1:0]  st_off,
    input  size_e       st_size,
    input  logic [31:0] st_wdata,
    output logic [3:0]  be_lo,
    output logic [3:0]  be_hi,
    output logic [31:0] wdata_lo,
    output logic [31:0] wdata_hi,
    input  logic [63:0] ld_word,
    input  logic [1:0]  ld_off,
    input  size_e       ld_size,
    input  logic        ld_unsigned,
    output logic [31:0] ld_data
);

    logic [7:0]  be_w;
    logic [63:0] wd_w;
    logic [63:0] ld_sh;

    // Shifting into a double-width window yields the spill-over lanes of the
    // second word directly in the upper half.
    always_comb begin
        be_w     = {4'b0000, lane_mask(st_size)} << st_off;
        wd_w     = {32'h0, st_wdata} << {st_off, 3'b000};
        be_lo    = be_w[3:0];
        be_hi    = be_w[7:4];
        wdata_lo = wd_w[31:0];
        wdata_hi = wd_w[63:32];
    end

    always_comb begin
        ld_sh = ld_word >> {ld_off, 3'b000};
        case (ld_size)
            SZ_B:    ld_data = {{24{~ld_unsigned & ld_sh[7]}}, ld_sh[7:0]};
            SZ_H:    ld_data = {{16{~ld_unsigned & ld_sh[15]}}, ld_sh[15:0]};
            default: ld_data = ld_sh[31:0];
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Core load/store front end for a single-port synchronous data RAM; splits
// misaligned accesses into two consecutive word accesses.
module data_mem_ctrl
    import data_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_i,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [1:0]            size_i,
    input  logic                  unsigned_i,
    input  logic [31:0]           addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  gnt_o,
    output logic                  rvalid_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  mem_en_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic [3:0]            mem_be_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    if (DATA_WIDTH != 32) begin : g_bad_width
        $error("data_mem_ctrl: DATA_WIDTH must be 32");
    end

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] req_word_q;
    logic [1:0]            req_off_q;
    size_e                 req_size_q;
    logic                  req_we_q;
    logic [31:0]           req_wdata_q;

    logic                  rsp_vld_q, rsp_we_q, rsp_uns_q, rsp_split_q;
    logic [1:0]            rsp_off_q;
    size_e                 rsp_size_q;
    logic [31:0]           hold_q;

    logic [1:0]  off;
    size_e       size_n;
    logic        mis, accept, issue2;
    logic [3:0]  be_lo, be_hi;
    logic [31:0] wdata_lo, wdata_hi, ld_data;
    logic [63:0] ld_word;
    logic        unused_addr;

    assign unused_addr = ^addr_i[31:ADDR_WIDTH];

    assign off    = addr_i[1:0];
    assign size_n = (size_i == 2'b11) ? SZ_W : size_e'(size_i);
    assign mis    = (size_n == SZ_H && off == 2'd3) || (size_n == SZ_W && off != 2'd0);
    // Reset gates issue combinationally so a pending second half never reaches the RAM.
    assign accept = !rst_i && state_q == IDLE && req_i;
    assign issue2 = !rst_i && state_q == SECOND;

    assign ld_word = rsp_split_q ? {mem_rdata_i, hold_q} : {32'h0, mem_rdata_i};

    lsu_align u_align (
        .st_off      (issue2 ? req_off_q   : off),
        .st_size     (issue2 ? req_size_q  : size_n),
        .st_wdata    (issue2 ? req_wdata_q : wdata_i),
        .be_lo       (be_lo),
        .be_hi       (be_hi),
        .wdata_lo    (wdata_lo),
        .wdata_hi    (wdata_hi),
        .ld_word     (ld_word),
        .ld_off      (rsp_off_q),
        .ld_size     (rsp_size_q),
        .ld_unsigned (rsp_uns_q),
        .ld_data     (ld_data)
    );

    always_comb begin
        state_d     = state_q;
        gnt_o       = accept;
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_be_o    = 4'b0000;
        if (accept) begin
            mem_en_o    = 1'b1;
            mem_we_o    = we_i;
            mem_addr_o  = {addr_i[ADDR_WIDTH-1:2], 2'b00};
            mem_be_o    = be_lo;
            mem_wdata_o = wdata_lo;
            if (mis) state_d = SECOND;
        end else if (issue2) begin
            mem_en_o    = 1'b1;
            mem_we_o    = req_we_q;
            mem_addr_o  = req_word_q + ADDR_WIDTH'(4);
            mem_be_o    = be_hi;
            mem_wdata_o = wdata_hi;
            state_d     = IDLE;
        end
    end

    assign rvalid_o = rsp_vld_q && !rst_i;
    assign rdata_o  = (rvalid_o && !rsp_we_q) ? ld_data : 32'h0;

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q     <= IDLE;
            req_word_q  <= '0;
            req_off_q   <= 2'b00;
            req_size_q  <= SZ_B;
            req_we_q    <= 1'b0;
            req_wdata_q <= 32'h0;
            rsp_vld_q   <= 1'b0;
            rsp_we_q    <= 1'b0;
            rsp_uns_q   <= 1'b0;
            rsp_split_q <= 1'b0;
            rsp_off_q   <= 2'b00;
            rsp_size_q  <= SZ_B;
            hold_q      <= 32'h0;
        end else begin
            state_q   <= state_d;
            rsp_vld_q <= (accept && !mis) || issue2;
            // The previous response is consumed in the grant cycle, so the
            // tracker can be reloaded here even for a split request.
            if (accept) begin
                req_word_q  <= {addr_i[ADDR_WIDTH-1:2], 2'b00};
                req_off_q   <= off;
                req_size_q  <= size_n;
                req_we_q    <= we_i;
                req_wdata_q <= wdata_i;
                rsp_we_q    <= we_i;
                rsp_uns_q   <= unsigned_i;
                rsp_split_q <= mis;
                rsp_off_q   <= off;
                rsp_size_q  <= size_n;
            end
            if (issue2) hold_q <= mem_rdata_i;
        end
    end

endmodule
